// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC and fetches one instruction word per handshake.
// It presents the word to decode and picks the next PC once the datapath advances.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        jump,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [31:0] jr_target
);

    localparam logic [5:0] OP_J   = 6'b010101;
    localparam logic [5:0] OP_JR  = 6'b010110;
    localparam logic [5:0] OP_JAL = 6'b010111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] next_pc;
    logic [31:0] branch_offset;

    assign imem_req    = (state_reg == FETCH);
    assign instr_valid = (state_reg == HOLD);
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign pc_plus4    = pc_reg + 32'd4;
    assign instr       = instr_reg;
    assign opcode      = instr_reg[31:26];

    // Jump beats branch; an unrecognised jump opcode falls through to sequential.
    always_comb begin
        branch_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
        next_pc       = pc_plus4;
        if (jump) begin
            if (opcode == OP_JR) begin
                next_pc = jr_target & 32'hFFFF_FFFC;
            end else if (opcode == OP_J || opcode == OP_JAL) begin
                next_pc = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
            end
        end else if (branch && branch_taken) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_reg <= imem_rdata;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        pc_reg    <= next_pc & 32'hFFFF_FFFC;
                        state_reg <= FETCH;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: directed PC-selection cases, then random
// instruction streams with random wait states, checked against a behavioural PC model.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        jump;
    logic        branch;
    logic        branch_taken;
    logic [31:0] jr_target;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } rec_t;

    rec_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] model_pc;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .advance(advance), .jump(jump), .branch(branch),
        .branch_taken(branch_taken), .jr_target(jr_target)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference next-PC rule, computed with plain arithmetic on the instruction fields.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic j, input logic b, input logic t,
                                               input logic [31:0] jrt);
        logic [31:0] seq;
        int          imm;
        seq = cur + 32'd4;
        if (j) begin
            if (word[31:26] == 6'd22) return jrt - (jrt % 4);
            if (word[31:26] == 6'd21 || word[31:26] == 6'd23)
                return (seq & 32'hF000_0000) | (32'(word[25:0]) * 4);
            return seq;
        end
        if (b && t) begin
            imm = int'($signed(word[15:0]));
            return seq + 32'(imm * 4);
        end
        return seq;
    endfunction

    // Monitor: compares each fetch handshake and each retired instruction with the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_ready) begin
                if (addr_q.size() == 0) begin
                    check("fetch_unexpected", imem_addr, 32'hxxxx_xxxx);
                end else begin
                    check("fetch_addr", imem_addr, addr_q.pop_front());
                end
            end
            if (instr_valid && advance) begin
                if (exp_q.size() == 0) begin
                    check("retire_unexpected", instr, 32'hxxxx_xxxx);
                end else begin
                    rec_t r;
                    r = exp_q.pop_front();
                    check("retire_instr", instr, r.word);
                    check("retire_opcode", 32'(opcode), 32'(r.word[31:26]));
                    check("retire_pc", pc, r.addr);
                    check("retire_pc_plus4", pc_plus4, r.addr + 32'd4);
                end
            end
        end
    end

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 with the DUT back in FETCH.
    task automatic run_instr(input logic [31:0] word, input int waits, input int hold,
                             input logic j, input logic b, input logic t, input logic [31:0] jrt);
        logic [31:0] nxt;
        for (int w = 0; w < waits; w++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            advance    = 1'($urandom);
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_valid", 32'(instr_valid), 32'd0);
            check("wait_addr", imem_addr, model_pc);
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        advance    = 1'($urandom);
        exp_q.push_back('{word: word, addr: model_pc});
        @(posedge clk); #1;
        check("capture_valid", 32'(instr_valid), 32'd1);
        check("capture_instr", instr, word);
        check("capture_opcode", 32'(opcode), 32'(word[31:26]));
        for (int h = 1; h < hold; h++) begin
            imem_ready   = 1'($urandom);
            imem_rdata   = $urandom;
            advance      = 1'b0;
            jump         = 1'($urandom);
            branch       = 1'($urandom);
            branch_taken = 1'($urandom);
            jr_target    = $urandom;
            @(posedge clk); #1;
        end
        imem_ready   = 1'($urandom);
        imem_rdata   = $urandom;
        advance      = 1'b1;
        jump         = j;
        branch       = b;
        branch_taken = t;
        jr_target    = jrt;
        nxt = model_next(model_pc, word, j, b, t, jrt);
        addr_q.push_back(nxt);
        model_pc = nxt;
        @(posedge clk); #1;
        advance    = 1'b0;
        imem_ready = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        check("after_adv_req", 32'(imem_req), 32'd1);
        check("after_adv_addr", imem_addr, nxt);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        check("idle_req", 32'(imem_req), 32'd0);
        check("idle_valid", 32'(instr_valid), 32'd0);
        model_pc = RESET_PC;
        addr_q.push_back(RESET_PC);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
    endtask

    initial begin
        logic [31:0] w;
        logic [5:0]  op;
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; advance = 1'b0;
        jump = 1'b0; branch = 1'b0; branch_taken = 1'b0; jr_target = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, RESET_PC);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        release_reset();

        run_instr(32'h2001_0005, 0, 1, 0, 0, 0, 32'h0);
        check("seq_pc", pc, 32'h4);
        run_instr(32'h8C22_0000, 3, 2, 0, 0, 0, 32'h0);
        run_instr({6'b010101, 26'h40}, 1, 1, 1, 0, 0, 32'h0);
        check("j_to_100", pc, 32'h100);
        run_instr(32'h1000_FFFE, 0, 2, 0, 1, 1, 32'h0);
        check("branch_taken", pc, 32'h0FC);
        run_instr({6'b010101, 26'h40}, 0, 1, 1, 0, 0, 32'h0);
        run_instr(32'h1000_FFFE, 2, 1, 0, 1, 0, 32'h0);
        check("branch_not_taken", pc, 32'h104);
        run_instr({6'b010110, 26'h0}, 0, 1, 1, 0, 0, 32'h100);
        run_instr({6'b010101, 26'h000_FFFE}, 0, 1, 1, 1, 1, 32'h0);
        check("jump_over_branch", pc, 32'h0003_FFF8);
        run_instr({6'b010110, 26'h0}, 0, 1, 1, 0, 0, 32'h1000_0000);
        run_instr({6'b010101, 26'h40}, 1, 1, 1, 0, 0, 32'h0);
        check("j_region", pc, 32'h1000_0100);
        run_instr({6'b010110, 26'h0}, 0, 1, 1, 0, 0, 32'h0000_0203);
        check("jr_align", pc, 32'h200);
        run_instr({6'b010111, 26'h3}, 0, 1, 1, 0, 0, 32'h0);
        check("jal", pc, 32'h0000_000C);
        run_instr(32'h0000_0020, 0, 1, 1, 0, 0, 32'h0);
        check("jump_other_op", pc, 32'h10);
        run_instr({6'b010110, 26'h0}, 0, 1, 1, 0, 0, 32'hFFFF_FFFC);
        run_instr(32'h0000_0020, 0, 1, 0, 0, 0, 32'h0);
        check("wrap_pc", pc, 32'h0);

        for (int n = 0; n < 250; n++) begin
            w  = $urandom;
            op = w[31:26];
            case ($urandom_range(0, 5))
                0: op = 6'b010101;
                1: op = 6'b010110;
                2: op = 6'b010111;
                3: op = 6'b000100;
                default: ;
            endcase
            w[31:26] = op;
            run_instr(w, $urandom_range(0, 3), $urandom_range(1, 3),
                      ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 5),
                      1'($urandom), $urandom);
        end

        run_instr({6'b010110, 26'h0}, 0, 1, 1, 0, 0, 32'h40);
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        check("midrst_pc", pc, RESET_PC);
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", instr, 32'h0);
        check("midrst_opcode", 32'(opcode), 32'd0);
        check("midrst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        addr_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        release_reset();
        check("post_rst_valid", 32'(instr_valid), 32'd0);
        run_instr(32'h2001_0005, 1, 1, 0, 0, 0, 32'h0);
        check("post_rst_pc", pc, RESET_PC + 32'd4);

        check("retire_queue_empty", 32'(exp_q.size()), 32'd0);
        check("fetch_queue_left", 32'(addr_q.size()), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that sits directly upstream of the control unit in the single-cycle datapath. It holds the program counter, fetches 32-bit instruction words from instruction memory over a request/ready handshake, and presents each word, with its opcode field, to the decode/control logic. Once the datapath signals that it has finished with the current instruction, the block picks the next PC (sequential, branch, jump, or jump-register) from that instruction's resolved control outputs.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ready  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr  out  32  registered current instruction.
- opcode  out  6  instr[31:26]; drives the control unit's instruction input.
- instr_valid  out  1  instr/opcode hold a fetched word awaiting execution.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, used as the JAL link value.
- advance  in  1  datapath has completed the current instruction.
- jump  in  1  control unit jump output for the current instruction.
- branch  in  1  control unit Branch output.
- branch_taken  in  1  ALU branch condition result.
- jr_target  in  32  register value used by JR.

## Operation
- FSM states:
  - IDLE: reset state; moves to FETCH unconditionally on the next edge.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready=1, instr<=imem_rdata and the FSM moves to HOLD. Otherwise it stays in FETCH with the address stable.
  - HOLD: instr_valid=1. On advance=1, pc<=next_pc and the FSM moves to FETCH. Otherwise it stays in HOLD and instr is stable.
- Output decode: imem_req=(state==FETCH) and instr_valid=(state==HOLD), both decoded from registered state.
- Ignored inputs: advance outside HOLD, and imem_ready outside FETCH.
- next_pc is evaluated in HOLD in priority order (first match wins):
  1. jump=1, opcode 010110 (JR): {jr_target[31:2], 2'b00}.
  2. jump=1, opcode 010101 (J) or 010111 (JAL): {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. jump=1, any other opcode: pc_plus4.
  4. branch=1 and branch_taken=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  5. Otherwise: pc_plus4.
- Jump has priority over branch when both are asserted.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC gives pc_plus4=0. Branch targets wrap the same way.
- pc bits [1:0] are always 0.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, opcode=0, pc_plus4=RESET_PC+4.
- Reset mid-operation: asserting reset in any state immediately forces the reset values. An outstanding request is abandoned, and an imem_ready arriving after reset is released and before the next FETCH is ignored.

## Timing
- Reset release: the first edge after release enters FETCH, so imem_req rises one cycle after release.
- Fetch latency: FETCH with imem_ready in cycle N makes instr_valid=1 and instr valid in cycle N+1. Memory wait states extend FETCH one cycle each.
- Fastest throughput is 2 cycles per instruction (FETCH with ready, then HOLD with advance).
- advance in cycle M updates pc on edge M+1, and imem_req is high with the new address in cycle M+1.
- jump, branch, branch_taken and jr_target are sampled only in the cycle advance=1. They must be stable, combinational results of the current instr.
- opcode changes only on the capture edge, so the control unit sees a stable opcode for the whole HOLD period.

## Test plan
- Reset then release, with imem_ready=0: pc=0, imem_req=0 and instr_valid=0 during reset. One cycle after release: imem_req=1, imem_addr=0.
- Sequential fetch: ready in the first FETCH cycle with rdata=32'h2001_0005 gives instr=32'h2001_0005, opcode=6'b001000, instr_valid=1. advance with no jump/branch then gives imem_addr=4 on the next cycle.
- Wait states: hold imem_ready=0 for 3 FETCH cycles. imem_req stays 1, imem_addr stays constant and instr_valid stays 0. Ready on the 4th cycle gives instr_valid=1 on the 5th.
- Branch at pc=32'h100 with imm 16'hFFFE:
  - branch=1, branch_taken=1 gives next pc=32'h0FC.
  - branch_taken=0 gives 32'h104.
  - branch=1 and jump=1 together give the jump target.
- Jumps:
  - pc=32'h1000_0000, J with instr[25:0]=26'h40 gives next pc=32'h1000_0100.
  - JR with jr_target=32'h0000_0203 gives 32'h0000_0200.
  - pc=32'hFFFF_FFFC sequential gives 0.
- Reset mid-FETCH at pc=32'h40: outputs return to reset values immediately. An imem_ready pulse in the first cycle after release (still IDLE) is ignored, and the next fetch is from RESET_PC.
